// File: rtl/spi_receive_con.sv
// SPI receive controller: oversamples CS/DCLK/CIPO with clk_in and assembles one word per line.
// Optional frame_err_out port enabled by defining SPI_RX_FRAME_ERR_EN.
module spi_receive_con #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned LINES           = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DATA_WIDTH_SIZE = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic [DATA_WIDTH-1:0] data_out [LINES],
  output logic                  data_valid_out,
`ifdef SPI_RX_FRAME_ERR_EN
  output logic                  frame_err_out,
`endif
  output logic                  busy_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [DATA_WIDTH_SIZE-1:0] LastBit = DATA_WIDTH_SIZE'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [LINES-1:0]       data_sync [SYNC_STAGES];

  logic                       cs_s, dclk_s, rise, trusted;
  logic [LINES-1:0]           data_s;
  logic                       cs_prev_q, dclk_prev_q, armed_q;
  logic [1:0]                 state_q;
  logic [DATA_WIDTH_SIZE-1:0] count_q;
  logic [DATA_WIDTH-1:0]      shift_q [LINES];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cs_sync   <= '1;
      dclk_sync <= '0;
      fill_q    <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_sync[i] <= '0;
    end else begin
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], chip_sel_in};
      dclk_sync    <= {dclk_sync[SYNC_STAGES-2:0], chip_clk_in};
      fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      data_sync[0] <= chip_data_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign dclk_s  = dclk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign rise    = dclk_s & ~dclk_prev_q;
  // cs_s only reflects the pin once the reset value has flushed out of the synchronizer.
  assign trusted = fill_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q        <= StIdle;
      count_q        <= '0;
      cs_prev_q      <= 1'b1;
      dclk_prev_q    <= 1'b0;
      armed_q        <= 1'b0;
      data_valid_out <= 1'b0;
      for (int l = 0; l < int'(LINES); l++) begin
        shift_q[l]  <= '0;
        data_out[l] <= '0;
      end
    end else begin
      cs_prev_q      <= cs_s;
      dclk_prev_q    <= dclk_s;
      data_valid_out <= 1'b0;
      // A frame may only start after CS has been seen high, so we never join mid-stream.
      if (trusted && cs_s) armed_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (armed_q && cs_prev_q && !cs_s) begin
            count_q <= '0;
            for (int l = 0; l < int'(LINES); l++) shift_q[l] <= '0;
            state_q <= StRecv;
          end
        end
        StRecv: begin
          if (cs_s) begin
            state_q <= StIdle;
          end else if (rise) begin
            count_q <= count_q + DATA_WIDTH_SIZE'(1);
            for (int l = 0; l < int'(LINES); l++) begin
              shift_q[l] <= {shift_q[l][DATA_WIDTH-2:0], data_s[l]};
            end
            if (count_q == LastBit) begin
              for (int l = 0; l < int'(LINES); l++) begin
                data_out[l] <= {shift_q[l][DATA_WIDTH-2:0], data_s[l]};
              end
              data_valid_out <= 1'b1;
              state_q        <= StDone;
            end
          end
        end
        StDone: begin
          if (cs_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      frame_err_out <= 1'b0;
    end else begin
      frame_err_out <= ((state_q == StRecv) && cs_s) || ((state_q == StDone) && rise);
    end
  end
`endif

  assign busy_out = (state_q != StIdle);

endmodule

// File: tb/tb_spi_receive_con.sv
// Bench for spi_receive_con (LINES=4): vector table of frames plus a reset-mid-frame sequence.
// Checks frame_err_out as well when SPI_RX_FRAME_ERR_EN is defined.
module tb_spi_receive_con;
  localparam int SYNC = 2;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [3:0] chip_data_in = '0;
  logic       chip_clk_in = 1'b0;
  logic       chip_sel_in = 1'b1;
  logic [7:0] data_out [4];
  logic       data_valid_out;
  logic       busy_out;
`ifdef SPI_RX_FRAME_ERR_EN
  logic       frame_err_out;
  int         err_cycles = 0;
  int         exp_err = 0;
`endif

  spi_receive_con #(
    .DATA_WIDTH (8),
    .LINES      (4),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .chip_data_in  (chip_data_in),
    .chip_clk_in   (chip_clk_in),
    .chip_sel_in   (chip_sel_in),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err_out (frame_err_out),
`endif
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] words;  // line l in bits [8l+7:8l]
    int          nbits;
    int          half;
    int          extra;
    bit          lat;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] sb_q [$];
  logic [31:0] last_words = '0;
  int n_checks = 0, n_err = 0;
  int cyc = 0, strobe_cnt = 0, exp_strobes = 0;
  int valid_cyc = 0, last_rise_cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [31:0] dout();
    return {data_out[3], data_out[2], data_out[1], data_out[0]};
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Scoreboard: each strobe must match the oldest pending frame.
  always @(negedge clk_in) begin
    if (rst_n_in && data_valid_out) begin
      strobe_cnt++;
      valid_cyc = cyc;
      if (sb_q.size() == 0) check("unexpected_strobe", dout(), 32'hxxxxxxxx);
      else check("strobe_data", dout(), sb_q.pop_front());
    end
`ifdef SPI_RX_FRAME_ERR_EN
    if (rst_n_in && frame_err_out) err_cycles++;
`endif
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_bits(input logic [31:0] w, input int first, input int last, input int half);
    for (int b = first; b <= last; b++) begin
      for (int l = 0; l < 4; l++) chip_data_in[l] = w[8*l+7-b];
      chip_clk_in = 1'b0;
      wait_cyc(half);
      chip_clk_in = 1'b1;
      last_rise_cyc = cyc;
      wait_cyc(half);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits, input int half, input int extra);
    chip_sel_in = 1'b0;
    wait_cyc(half);
    send_bits(w, 0, nbits - 1, half);
    for (int e = 0; e < extra; e++) begin
      chip_clk_in = 1'b0;
      wait_cyc(half);
      chip_clk_in = 1'b1;
      wait_cyc(half);
    end
    chip_clk_in = 1'b0;
    wait_cyc(half);
    chip_sel_in = 1'b1;
    wait_cyc(half + 10);
  endtask

  initial begin
    vecs[0] = '{32'h000000A5, 8, 50, 0, 1'b0};
    vecs[1] = '{32'h78563412, 8, 10, 0, 1'b0};
    vecs[2] = '{32'h7E8100FF, 8, 10, 0, 1'b0};
    vecs[3] = '{32'hDEADBEEF, 5, 10, 0, 1'b0};
    vecs[4] = '{32'h0000005A, 8, SYNC + 2, 0, 1'b1};
    vecs[5] = '{32'h11223344, 8, 10, 2, 1'b0};

    wait_cyc(2);
    check("reset_valid", {31'd0, data_valid_out}, 32'd0);
    check("reset_busy", {31'd0, busy_out}, 32'd0);
    rst_n_in = 1'b1;
    wait_cyc(5);
    check("reset_data", dout(), 32'd0);
    check("idle_busy", {31'd0, busy_out}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].nbits == 8) begin
        sb_q.push_back(vecs[i].words);
        last_words = vecs[i].words;
        exp_strobes++;
      end
`ifdef SPI_RX_FRAME_ERR_EN
      exp_err += ((vecs[i].nbits < 8) ? 1 : 0) + vecs[i].extra;
`endif
      send_frame(vecs[i].words, vecs[i].nbits, vecs[i].half, vecs[i].extra);
      check($sformatf("strobes_v%0d", i), strobe_cnt, exp_strobes);
      check($sformatf("busy_v%0d", i), {31'd0, busy_out}, 32'd0);
      check($sformatf("hold_v%0d", i), dout(), last_words);
      if (vecs[i].lat) check("latency", valid_cyc - last_rise_cyc, SYNC + 1);
    end

    // Reset after bit 3 of 0xC3 with CS held low: the frame must be dropped.
    chip_sel_in = 1'b0;
    wait_cyc(10);
    send_bits(32'h000000C3, 0, 3, 10);
    rst_n_in = 1'b0;
    wait_cyc(1);
    rst_n_in = 1'b1;
    last_words = '0;
    check("midreset_busy", {31'd0, busy_out}, 32'd0);
    check("midreset_data", dout(), 32'd0);
    send_bits(32'h000000C3, 4, 7, 10);
    chip_clk_in = 1'b0;
    wait_cyc(10);
    check("midreset_busy_cs_low", {31'd0, busy_out}, 32'd0);
    chip_sel_in = 1'b1;
    wait_cyc(20);
    check("midreset_strobes", strobe_cnt, exp_strobes);
    check("midreset_hold", dout(), 32'd0);

    sb_q.push_back(32'h0000003C);
    exp_strobes++;
    send_frame(32'h0000003C, 8, 10, 0);
    check("after_reset_strobes", strobe_cnt, exp_strobes);
    check("after_reset_data", dout(), 32'h0000003C);

    check("sb_empty", sb_q.size(), 0);
`ifdef SPI_RX_FRAME_ERR_EN
    check("frame_err_cycles", err_cycles, exp_err);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
